ula_seq: RTL and testbench

- Accumulator-based sequencer that drives the team's 4-bit combinational ALU (3-bit selector, 4-bit result, carry_out) through external ALU ports.
- Accepts commands over a valid/ready handshake and applies single ALU operations to a 4-bit accumulator.
- Also runs LOAD, CLR, and a multi-cycle 4x4 shift-add multiply that reuses the ALU adder (selector 010).
- Sits between a simple command source (FSM/testbench) and the ALU instance.

---
 rtl/ula_seq.sv | 203 ++++++++++++++++++++
 tb/tb_ula_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
//------------------------------------------------------------------------------
// Module  : ula_seq
// Brief   : Accumulator sequencer driving an external 4-bit ALU. It handles
//           single ALU ops, LOAD, CLR and a 4-cycle shift-add multiply.
//           Optional macro ULA_SEQ_CNT_EN adds a saturating op_count output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ula_seq #(
  parameter logic [3:0] ACC_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  output logic [3:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       err,
  output logic       busy,
  output logic       done
`ifdef ULA_SEQ_CNT_EN
  ,output logic [7:0] op_count
`endif
);

  localparam logic [3:0] c_OP_LOAD = 4'b1000;
  localparam logic [3:0] c_OP_MUL  = 4'b1001;
  localparam logic [3:0] c_OP_CLR  = 4'b1010;
  localparam logic [2:0] c_SEL_ADD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] data_q, data_d;
  logic [3:0] acc_q, acc_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;
  logic       err_q, err_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] p_q, p_d;
  logic [1:0] iter_q, iter_d;
  logic       ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sel_q    <= 3'b000;
      data_q   <= 4'h0;
      acc_q    <= ACC_RST;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      err_q    <= 1'b0;
      m_q      <= 4'h0;
      q_q      <= 4'h0;
      p_q      <= 4'h0;
      iter_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      err_q    <= err_d;
      m_q      <= m_d;
      q_q      <= q_d;
      p_q      <= p_d;
      iter_q   <= iter_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    err_d    = err_q;
    m_d      = m_q;
    q_d      = q_q;
    p_d      = p_q;
    iter_d   = iter_q;
    ovf_d    = ovf_q;
    alu_a    = acc_q;
    alu_b    = 4'h0;
    alu_sel  = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          sel_d  = cmd_op[2:0];
          data_d = cmd_data;
          if (!cmd_op[3]) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_DONE;
            case (cmd_op)
              c_OP_LOAD: begin
                acc_d    = cmd_data;
                flag_c_d = 1'b0;
                flag_z_d = (cmd_data == 4'h0);
                err_d    = 1'b0;
              end
              c_OP_CLR: begin
                acc_d    = 4'h0;
                flag_c_d = 1'b0;
                flag_z_d = 1'b1;
                err_d    = 1'b0;
              end
              c_OP_MUL: begin
                state_d = S_MUL;
                m_d     = acc_q;
                q_d     = cmd_data;
                p_d     = 4'h0;
                iter_d  = 2'd0;
                ovf_d   = 1'b0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
      end

      S_EXEC: begin
        alu_b    = data_q;
        alu_sel  = sel_q;
        acc_d    = alu_res;
        flag_c_d = alu_cout;
        flag_z_d = (alu_res == 4'h0);
        err_d    = 1'b0;
        state_d  = S_DONE;
      end

      S_MUL: begin
        alu_a   = p_q;
        alu_b   = m_q;
        alu_sel = c_SEL_ADD;
        if (q_q[0]) begin
          p_d   = alu_res;
          ovf_d = ovf_d | alu_cout;
        end
        // A set MSB about to be shifted out still has multiplier bits pending.
        ovf_d  = ovf_d | (m_q[3] && (q_q[3:1] != 3'b000));
        m_d    = m_q << 1;
        q_d    = q_q >> 1;
        iter_d = iter_q + 2'd1;
        if (iter_q == 2'd3) begin
          acc_d    = p_d;
          flag_c_d = ovf_d;
          flag_z_d = (p_d == 4'h0);
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign acc       = acc_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign err       = err_q;

`ifdef ULA_SEQ_CNT_EN
  logic [7:0] op_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= 8'h00;
    end else if (state_q == S_DONE && op_count_q != 8'hFF) begin
      op_count_q <= op_count_q + 8'h01;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ula_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_ula_seq
// Brief   : Directed self-checking bench for ula_seq with a behavioural ALU.
// Revision: 1.1 - checks routed through a checking task
//------------------------------------------------------------------------------
`default_nettype none

module tb_ula_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_res;
    logic       alu_cout;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       err;
    logic       busy;
    logic       done;
`ifdef ULA_SEQ_CNT_EN
    logic [7:0] op_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ula_seq dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_res  (alu_res),
        .alu_cout (alu_cout),
        .acc      (acc),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .err      (err),
        .busy     (busy),
        .done     (done)
`ifdef ULA_SEQ_CNT_EN
        ,.op_count(op_count)
`endif
    );

    // Stand-in for the team ALU: add/sub produce carry, all others carry 0.
    always_comb begin
        logic [4:0] w_sum;
        w_sum    = 5'd0;
        alu_cout = 1'b0;
        alu_res  = 4'h0;
        case (alu_sel)
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b010: begin
                w_sum    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res  = w_sum[3:0];
                alu_cout = w_sum[4];
            end
            3'b011: alu_res = alu_a ^ alu_b;
            3'b100: alu_res = ~alu_a;
            3'b101: alu_res = ~(alu_a & alu_b);
            3'b110: begin
                w_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_res  = w_sum[3:0];
                alu_cout = w_sum[4];
            end
            default: alu_res = alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for a single edge; afterwards the DUT is at T+1ns.
    task automatic send(input logic [3:0] op, input logic [3:0] d);
        check("ready_before_send", {7'd0, cmd_ready}, 8'h01);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
    endtask

    task automatic load(input logic [3:0] d);
        send(4'b1000, d);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_data  = 4'h0;
        tick();
        tick();
        check("rst_acc", {4'd0, acc}, 8'h00);
        check("rst_done", {7'd0, done}, 8'h00);
        check("rst_flag_c", {7'd0, flag_c}, 8'h00);
        check("rst_flag_z", {7'd0, flag_z}, 8'h00);
        check("rst_err", {7'd0, err}, 8'h00);
`ifdef ULA_SEQ_CNT_EN
        check("rst_op_count", op_count, 8'h00);
`endif
        reset = 1'b0;
        tick();
        check("idle_busy", {7'd0, busy}, 8'h00);
        check("idle_ready", {7'd0, cmd_ready}, 8'h01);
        check("idle_alu_sel", {5'd0, alu_sel}, 8'h00);
        check("idle_alu_b", {4'd0, alu_b}, 8'h00);

        // LOAD 5: DONE directly after the accept edge
        send(4'b1000, 4'h5);
        check("load_done", {7'd0, done}, 8'h01);
        check("load_ready_low", {7'd0, cmd_ready}, 8'h00);
        check("load_acc", {4'd0, acc}, 8'h05);
        check("load_z", {7'd0, flag_z}, 8'h00);
        check("load_c", {7'd0, flag_c}, 8'h00);
        tick();
        check("load_done_drop", {7'd0, done}, 8'h00);

        // SUB 5-3
        send(4'b0110, 4'h3);
        check("sub1_sel", {5'd0, alu_sel}, 8'h06);
        check("sub1_a", {4'd0, alu_a}, 8'h05);
        check("sub1_b", {4'd0, alu_b}, 8'h03);
        check("sub1_exec_nodone", {7'd0, done}, 8'h00);
        tick();
        check("sub1_done", {7'd0, done}, 8'h01);
        check("sub1_acc", {4'd0, acc}, 8'h02);
        check("sub1_c", {7'd0, flag_c}, 8'h01);
        tick();

        // SUB 3-5 borrows
        load(4'h3);
        send(4'b0110, 4'h5);
        tick();
        check("sub2_acc", {4'd0, acc}, 8'h0e);
        check("sub2_c", {7'd0, flag_c}, 8'h00);
        tick();

        // ADD 9+8 wraps
        load(4'h9);
        send(4'b0010, 4'h8);
        tick();
        check("add_acc", {4'd0, acc}, 8'h01);
        check("add_c", {7'd0, flag_c}, 8'h01);
        check("add_z", {7'd0, flag_z}, 8'h00);
        tick();

        // CLR then AND with F
        send(4'b1010, 4'h7);
        check("clr_acc", {4'd0, acc}, 8'h00);
        check("clr_z", {7'd0, flag_z}, 8'h01);
        tick();
        send(4'b0000, 4'hf);
        tick();
        check("and_acc", {4'd0, acc}, 8'h00);
        check("and_z", {7'd0, flag_z}, 8'h01);
        check("and_c", {7'd0, flag_c}, 8'h00);
        tick();

        // MUL 3*5 = 15
        load(4'h3);
        send(4'b1001, 4'h5);
        for (int i = 0; i < 4; i++) begin
            check("mul1_busy", {7'd0, busy}, 8'h01);
            check("mul1_nodone", {7'd0, done}, 8'h00);
            check("mul1_sel", {5'd0, alu_sel}, 8'h02);
            tick();
        end
        check("mul1_done", {7'd0, done}, 8'h01);
        check("mul1_acc", {4'd0, acc}, 8'h0f);
        check("mul1_c", {7'd0, flag_c}, 8'h00);
        check("mul1_z", {7'd0, flag_z}, 8'h00);
        tick();

        // MUL 4*4 = 16 -> overflow to zero
        load(4'h4);
        send(4'b1001, 4'h4);
        repeat (4) tick();
        check("mul2_done", {7'd0, done}, 8'h01);
        check("mul2_acc", {4'd0, acc}, 8'h00);
        check("mul2_c", {7'd0, flag_c}, 8'h01);
        check("mul2_z", {7'd0, flag_z}, 8'h01);
        tick();

        // MUL F*F = 225 -> low nibble 1
        load(4'hf);
        send(4'b1001, 4'hf);
        repeat (4) tick();
        check("mul3_done", {7'd0, done}, 8'h01);
        check("mul3_acc", {4'd0, acc}, 8'h01);
        check("mul3_c", {7'd0, flag_c}, 8'h01);
        check("mul3_z", {7'd0, flag_z}, 8'h00);
        tick();

        // Illegal op leaves acc/flags, raises err
        load(4'h7);
        send(4'b1111, 4'h2);
        check("ill_done", {7'd0, done}, 8'h01);
        check("ill_err", {7'd0, err}, 8'h01);
        check("ill_acc", {4'd0, acc}, 8'h07);
        check("ill_c", {7'd0, flag_c}, 8'h00);
        check("ill_z", {7'd0, flag_z}, 8'h00);
        tick();

        // ADD with valid held high and data changed while busy
        cmd_valid = 1'b1;
        cmd_op    = 4'b0010;
        cmd_data  = 4'h1;
        tick();
        cmd_data  = 4'hf;
        check("hold_exec_ready", {7'd0, cmd_ready}, 8'h00);
        tick();
        check("hold_done", {7'd0, done}, 8'h01);
        check("hold_acc", {4'd0, acc}, 8'h08);
        check("hold_err_clear", {7'd0, err}, 8'h00);
        tick();
        check("hold_back_idle", {7'd0, busy}, 8'h00);
        cmd_valid = 1'b0;
        tick();

        // Reset during MUL iteration 2
        load(4'h3);
        send(4'b1001, 4'h5);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_acc", {4'd0, acc}, 8'h00);
        check("mrst_busy", {7'd0, busy}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            check("mrst_nodone", {7'd0, done}, 8'h00);
            tick();
        end

`ifdef ULA_SEQ_CNT_EN
        check("cnt_after_rst", op_count, 8'h00);
        for (int i = 0; i < 300; i++) begin
            send(4'b1010, 4'h0);
            tick();
        end
        check("cnt_saturate", op_count, 8'hff);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
